// File: rtl/reg_writeback.sv
// Write-back sequencer: merges ALU results and in-order load returns into the
// single register-file write port, and flags ID-stage sources with writes in flight.
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_addr_i,
    input  logic [31:0] alu_data_i,
    input  logic        ld_req_i,
    input  logic [4:0]  ld_addr_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_data_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic        RegWrite_o,
    output logic        wr_ready_o,
    output logic        ld_ready_o,
    output logic        RSbusy_o,
    output logic        RTbusy_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t         wq_mem [DEPTH];
    logic [AW-1:0]     wq_rd, wq_wr;
    logic [CW-1:0]     wcnt;

    logic [4:0]        tq_mem [DEPTH];
    logic [AW-1:0]     tq_rd, tq_wr;
    logic [CW-1:0]     tcnt;

    logic              tag_pop, tag_push, arr_drop, ld_keep, alu_keep;
    logic              q_pop, have_out, push0_en, push1_en, err_now;
    logic [1:0]        n_arr, n_push;
    wb_entry_t         ld_entry, alu_entry, arr0, arr1, out_entry, push0, push1;
    logic [CW-1:0]     wcnt_next, tcnt_next;

    assign wr_ready_o = (wcnt < CW'(DEPTH));
    assign ld_ready_o = (tcnt < CW'(DEPTH));

    // NOTE: every signal assigned in always_comb gets a default at the top so no path leaves it unassigned and infers a latch.
    always_comb begin
        tag_pop   = ld_valid_i && (tcnt != '0);
        tag_push  = ld_req_i && ld_ready_o;
        ld_entry  = '{addr: tq_mem[tq_rd], data: ld_data_i};
        alu_entry = '{addr: alu_addr_i, data: alu_data_i};

        // An overflowing cycle loses all of its arrivals, but the popped tag is still spent.
        arr_drop  = (alu_valid_i || tag_pop) && !wr_ready_o;
        ld_keep   = tag_pop && (ld_entry.addr != 5'd0) && !arr_drop;
        alu_keep  = alu_valid_i && (alu_addr_i != 5'd0) && !arr_drop;
        n_arr     = {1'b0, ld_keep} + {1'b0, alu_keep};
        arr0      = ld_keep ? ld_entry : alu_entry;
        arr1      = alu_entry;

        q_pop     = (wcnt != '0);
        have_out  = q_pop || (n_arr != 2'd0);
        out_entry = q_pop ? wq_mem[wq_rd] : arr0;

        push0     = arr0;
        push1     = arr1;
        push0_en  = 1'b0;
        push1_en  = 1'b0;
        n_push    = 2'd0;
        if (q_pop) begin
            push0_en = (n_arr != 2'd0);
            push1_en = (n_arr == 2'd2);
            n_push   = n_arr;
        end else if (n_arr == 2'd2) begin
            push0    = arr1;
            push0_en = 1'b1;
            n_push   = 2'd1;
        end

        wcnt_next = wcnt + CW'(n_push) - CW'(q_pop);
        tcnt_next = tcnt + CW'(tag_push) - CW'(tag_pop);
        err_now   = arr_drop || (ld_req_i && !ld_ready_o) || (ld_valid_i && (tcnt == '0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
            err_o      <= 1'b0;
            wq_rd      <= '0;
            wq_wr      <= '0;
            wcnt       <= '0;
            tq_rd      <= '0;
            tq_wr      <= '0;
            tcnt       <= '0;
        end else begin
            err_o      <= err_o || err_now;
            RegWrite_o <= have_out;
            if (have_out) begin
                RDaddr_o <= out_entry.addr;
                RDdata_o <= out_entry.data;
            end
            if (q_pop)
                wq_rd <= wq_rd + AW'(1);
            wq_wr <= wq_wr + AW'(n_push);
            wcnt  <= wcnt_next;
            if (tag_push)
                tq_wr <= tq_wr + AW'(1);
            if (tag_pop)
                tq_rd <= tq_rd + AW'(1);
            tcnt <= tcnt_next;
        end
    end

    // NOTE: queue storage is not reset; validity comes from the reset pointers and counts.
    always_ff @(posedge clk_i) begin
        if (push0_en)
            wq_mem[wq_wr] <= push0;
        if (push1_en)
            wq_mem[wq_wr + AW'(1)] <= push1;
        if (tag_push)
            tq_mem[tq_wr] <= ld_addr_i;
    end

    // An entry is live when its distance from the read pointer is below the count.
    logic          rs_hit, rt_hit;
    logic [AW-1:0] w_off, t_off;
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        w_off  = '0;
        t_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - wq_rd;
            t_off = AW'(i) - tq_rd;
            if (({1'b0, w_off} < wcnt) && (wq_mem[i].addr == RSaddr_i)) rs_hit = 1'b1;
            if (({1'b0, w_off} < wcnt) && (wq_mem[i].addr == RTaddr_i)) rt_hit = 1'b1;
            if (({1'b0, t_off} < tcnt) && (tq_mem[i] == RSaddr_i))      rs_hit = 1'b1;
            if (({1'b0, t_off} < tcnt) && (tq_mem[i] == RTaddr_i))      rt_hit = 1'b1;
        end
    end

    assign RSbusy_o = rs_hit && (RSaddr_i != 5'd0);
    assign RTbusy_o = rt_hit && (RTaddr_i != 5'd0);

endmodule
